rca_result_writeback: RTL and testbench

- Writeback-side counterpart to the RCA issue control.
- Takes result words from the grid output-unit result FIFO and pairs each with the oldest in-flight RCA instruction ID from the issue-side ID FIFO.
- Presents the pair to the Taiga writeback stage.
- On commit, pulses wb_committing, which pops the issue-side ID FIFO.
- For feedback (fb) instructions, consumes intermediate iteration results and writes back only the final one.

---
 rtl/rca_result_writeback.sv | 135 +++++++++++++
 tb/tb_rca_result_writeback.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_result_writeback.sv
// Writeback side of the RCA: pairs grid results with the oldest in-flight instruction ID,
// drops intermediate feedback iterations and presents the final result to writeback.
module rca_result_writeback #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned ITER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_populated,
    input  logic [ID_WIDTH-1:0]   wb_id,
    input  logic                  wb_fb_instr,
    input  logic                  clear_fifos,
    input  logic                  result_valid,
    input  logic [XLEN-1:0]       result_data,
    input  logic                  result_last,
    output logic                  result_pop,
    output logic                  wb_done,
    output logic [XLEN-1:0]       wb_rd,
    output logic [ID_WIDTH-1:0]   wb_id_out,
    input  logic                  wb_ack,
    output logic                  wb_committing,
    output logic [ITER_WIDTH-1:0] fb_iter_count,
    output logic                  protocol_err
);

    localparam logic [ITER_WIDTH-1:0] ITER_MAX = '1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_RESULT = 2'd1,
        PRESENT     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  fb_q, fb_d;
    logic                  wb_done_q, wb_done_d;
    logic [XLEN-1:0]       wb_rd_q, wb_rd_d;
    logic [ID_WIDTH-1:0]   wb_id_q, wb_id_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic                  err_q, err_d;

    // Next-state and combinational handshake outputs; rst suppresses every pulse.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        fb_d          = fb_q;
        wb_done_d     = wb_done_q;
        wb_rd_d       = wb_rd_q;
        wb_id_d       = wb_id_q;
        iter_d        = iter_q;
        err_d         = err_q;
        result_pop    = 1'b0;
        wb_committing = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (fifo_populated) begin
                        state_d = WAIT_RESULT;
                        id_d    = wb_id;
                        fb_d    = wb_fb_instr;
                        iter_d  = '0;
                    end
                end
                WAIT_RESULT: begin
                    result_pop = result_valid;
                    if (clear_fifos) begin
                        err_d     = 1'b1;
                        wb_done_d = 1'b0;
                        state_d   = IDLE;
                    end else if (result_valid) begin
                        if (fb_q && !result_last) begin
                            if (iter_q != ITER_MAX) begin
                                iter_d = iter_q + ITER_WIDTH'(1);
                            end
                        end else begin
                            wb_rd_d   = result_data;
                            wb_id_d   = id_q;
                            wb_done_d = 1'b1;
                            state_d   = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    // A concurrent clear abandons the instruction even if acked.
                    if (clear_fifos) begin
                        err_d     = 1'b1;
                        wb_done_d = 1'b0;
                        state_d   = IDLE;
                    end else if (wb_ack) begin
                        wb_committing = 1'b1;
                        wb_done_d     = 1'b0;
                        state_d       = IDLE;
                    end
                end
                default: begin
                    wb_done_d = 1'b0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            fb_q      <= 1'b0;
            wb_done_q <= 1'b0;
            wb_rd_q   <= '0;
            wb_id_q   <= '0;
            iter_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            fb_q      <= fb_d;
            wb_done_q <= wb_done_d;
            wb_rd_q   <= wb_rd_d;
            wb_id_q   <= wb_id_d;
            iter_q    <= iter_d;
            err_q     <= err_d;
        end
    end

    assign wb_done       = wb_done_q;
    assign wb_rd         = wb_rd_q;
    assign wb_id_out     = wb_id_q;
    assign fb_iter_count = iter_q;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_rca_result_writeback.sv
// Bench for rca_result_writeback: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_rca_result_writeback;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IDW  = 3;
    localparam int unsigned IW   = 4;
    localparam int          ITER_SAT = (1 << IW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            fifo_populated;
    logic [IDW-1:0]  wb_id;
    logic            wb_fb_instr;
    logic            clear_fifos;
    logic            result_valid;
    logic [XLEN-1:0] result_data;
    logic            result_last;
    logic            result_pop;
    logic            wb_done;
    logic [XLEN-1:0] wb_rd;
    logic [IDW-1:0]  wb_id_out;
    logic            wb_ack;
    logic            wb_committing;
    logic [IW-1:0]   fb_iter_count;
    logic            protocol_err;

    rca_result_writeback #(.XLEN(XLEN), .ID_WIDTH(IDW), .ITER_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .fifo_populated(fifo_populated), .wb_id(wb_id), .wb_fb_instr(wb_fb_instr),
        .clear_fifos(clear_fifos),
        .result_valid(result_valid), .result_data(result_data), .result_last(result_last),
        .result_pop(result_pop),
        .wb_done(wb_done), .wb_rd(wb_rd), .wb_id_out(wb_id_out),
        .wb_ack(wb_ack), .wb_committing(wb_committing),
        .fb_iter_count(fb_iter_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Transaction-level model: is an instruction owned, has its result been captured.
    bit             model_on = 0;
    bit             m_busy, m_ready, m_fb, m_err;
    int             m_iter;
    logic [IDW-1:0] m_id, m_idout;
    logic [31:0]    m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("result_pop",    32'(result_pop),    32'(!rst && m_busy && !m_ready && result_valid));
        chk("wb_committing", 32'(wb_committing), 32'(!rst && m_ready && wb_ack && !clear_fifos));
        chk("wb_done",       32'(wb_done),       32'(m_ready));
        chk("wb_rd",         wb_rd,              m_rd);
        chk("wb_id_out",     32'(wb_id_out),     32'(m_idout));
        chk("fb_iter_count", 32'(fb_iter_count), 32'(m_iter));
        chk("protocol_err",  32'(protocol_err),  32'(m_err));
    endtask

    task automatic model_advance();
        if (rst) begin
            m_busy = 0; m_ready = 0; m_fb = 0; m_err = 0; m_iter = 0;
            m_id = '0; m_idout = '0; m_rd = '0;
        end else if (!m_busy) begin
            if (fifo_populated) begin
                m_busy = 1; m_id = wb_id; m_fb = wb_fb_instr; m_iter = 0;
            end
        end else if (clear_fifos) begin
            m_busy = 0; m_ready = 0; m_err = 1;
        end else if (m_ready) begin
            if (wb_ack) begin
                m_busy = 0; m_ready = 0;
            end
        end else if (result_valid) begin
            if (m_fb && !result_last) begin
                if (m_iter < ITER_SAT) m_iter++;
            end else begin
                m_rd = result_data; m_idout = m_id; m_ready = 1;
            end
        end
        model_on = 1;
    endtask

    // One clock: inputs already set after a negedge; check, advance model, next negedge.
    task automatic tick();
        #1;
        if (model_on) model_check();
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; fifo_populated = 0; wb_id = '0; wb_fb_instr = 0; clear_fifos = 0;
        result_valid = 0; result_data = '0; result_last = 0; wb_ack = 0;
    endtask

    // From IDLE, bring a non-fb instruction to PRESENT with the given ID and data.
    task automatic present(input logic [IDW-1:0] id, input logic [31:0] d);
        fifo_populated = 1; wb_id = id; wb_fb_instr = 0; result_valid = 0; wb_ack = 0;
        tick();
        result_valid = 1; result_data = d; result_last = 0;
        tick();
        result_valid = 0;
    endtask

    logic [IDW-1:0] idq[$];
    logic [31:0]    rq[$];
    int             n_commit, commit1_cyc, done2_cyc;
    logic [IDW-1:0] c_id[2];
    logic [31:0]    c_data[2];
    bit             obs_pop, obs_commit;

    initial begin
        idle_inputs();
        @(negedge clk);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("reset wb_done", 32'(wb_done), 32'd0);
        chk("reset wb_rd", wb_rd, 32'd0);
        chk("reset wb_id_out", 32'(wb_id_out), 32'd0);
        chk("reset fb_iter_count", 32'(fb_iter_count), 32'd0);
        chk("reset protocol_err", 32'(protocol_err), 32'd0);
        chk("reset result_pop", 32'(result_pop), 32'd0);

        // Non-fb single result.
        fifo_populated = 1; wb_id = 3'd5; wb_fb_instr = 0;
        tick();
        tick();
        result_valid = 1; result_data = 32'hDEADBEEF;
        #1 chk("nonfb pop", 32'(result_pop), 32'd1);
        tick();
        result_valid = 0;
        #1;
        chk("nonfb done", 32'(wb_done), 32'd1);
        chk("nonfb rd", wb_rd, 32'hDEADBEEF);
        chk("nonfb id", 32'(wb_id_out), 32'd5);
        wb_ack = 1;
        #1 chk("nonfb commit", 32'(wb_committing), 32'd1);
        tick();
        fifo_populated = 0; wb_ack = 0;
        #1 chk("nonfb done after", 32'(wb_done), 32'd0);
        tick();

        // Feedback instruction: three intermediates then the final value.
        fifo_populated = 1; wb_id = 3'd2; wb_fb_instr = 1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            result_valid = 1; result_data = 32'(k); result_last = (k == 4);
            #1 chk("fb pop", 32'(result_pop), 32'd1);
            if (k < 4) chk("fb no done", 32'(wb_done), 32'd0);
            tick();
        end
        result_valid = 0; result_last = 0;
        #1;
        chk("fb iter", 32'(fb_iter_count), 32'd3);
        chk("fb done", 32'(wb_done), 32'd1);
        chk("fb rd", wb_rd, 32'h4);
        chk("fb id", 32'(wb_id_out), 32'd2);
        wb_ack = 1;
        tick();
        wb_ack = 0; fifo_populated = 0;
        tick();

        // Counter saturation, held after commit.
        fifo_populated = 1; wb_id = 3'd6; wb_fb_instr = 1;
        tick();
        for (int k = 0; k < 20; k++) begin
            result_valid = 1; result_data = 32'(100 + k); result_last = 0;
            tick();
        end
        result_last = 1; result_data = 32'h55;
        tick();
        result_valid = 0; result_last = 0;
        #1 chk("fb sat iter", 32'(fb_iter_count), 32'(ITER_SAT));
        wb_ack = 1;
        tick();
        wb_ack = 0; fifo_populated = 0; wb_fb_instr = 0;
        #1 chk("fb iter holds", 32'(fb_iter_count), 32'(ITER_SAT));
        tick();

        // Back-to-back with a small environment modelling both FIFOs.
        idq = '{3'd1, 3'd3};
        rq  = '{32'h10, 32'h20};
        n_commit = 0; commit1_cyc = -1; done2_cyc = -1;
        wb_ack = 1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            fifo_populated = (idq.size() != 0);
            wb_id          = (idq.size() != 0) ? idq[0] : '0;
            result_valid   = (rq.size() != 0);
            result_data    = (rq.size() != 0) ? rq[0] : '0;
            #1;
            obs_pop = result_pop; obs_commit = wb_committing;
            if (wb_done && commit1_cyc >= 0 && done2_cyc < 0) done2_cyc = cyc;
            if (obs_commit) begin
                if (n_commit < 2) begin
                    c_id[n_commit] = wb_id_out; c_data[n_commit] = wb_rd;
                end
                if (n_commit == 0) commit1_cyc = cyc;
                n_commit++;
            end
            tick();
            if (obs_pop && rq.size() != 0) void'(rq.pop_front());
            if (obs_commit && idq.size() != 0) void'(idq.pop_front());
        end
        wb_ack = 0; fifo_populated = 0; result_valid = 0;
        chk("b2b commits", 32'(n_commit), 32'd2);
        chk("b2b id1", 32'(c_id[0]), 32'd1);
        chk("b2b data1", c_data[0], 32'h10);
        chk("b2b id2", 32'(c_id[1]), 32'd3);
        chk("b2b data2", c_data[1], 32'h20);
        chk("b2b bubble", 32'(done2_cyc >= commit1_cyc + 2), 32'd1);
        tick();

        // Writeback stall with a valid result waiting.
        present(3'd6, 32'hCAFE0001);
        result_valid = 1; result_data = 32'h1234;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall pop", 32'(result_pop), 32'd0);
            chk("stall rd", wb_rd, 32'hCAFE0001);
            chk("stall id", 32'(wb_id_out), 32'd6);
            chk("stall commit", 32'(wb_committing), 32'd0);
            tick();
        end
        wb_ack = 1;
        #1 chk("stall commit6", 32'(wb_committing), 32'd1);
        tick();
        wb_ack = 0; fifo_populated = 0; result_valid = 0;
        tick();

        // Result arrives before the ID.
        result_valid = 1; result_data = 32'h77;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("early pop", 32'(result_pop), 32'd0);
            chk("early done", 32'(wb_done), 32'd0);
            tick();
        end
        fifo_populated = 1; wb_id = 3'd4;
        #1 chk("early pop same cyc", 32'(result_pop), 32'd0);
        tick();
        #1 chk("early pop next cyc", 32'(result_pop), 32'd1);
        tick();
        result_valid = 0; wb_ack = 1;
        tick();
        wb_ack = 0; fifo_populated = 0;
        tick();

        // clear_fifos beats wb_ack, then reset mid-instruction.
        present(3'd7, 32'hABCD);
        clear_fifos = 1; wb_ack = 1;
        #1 chk("clear commit", 32'(wb_committing), 32'd0);
        tick();
        clear_fifos = 0; wb_ack = 0; fifo_populated = 0;
        #1;
        chk("clear err", 32'(protocol_err), 32'd1);
        chk("clear done", 32'(wb_done), 32'd0);
        tick();
        fifo_populated = 1; wb_id = 3'd3; wb_fb_instr = 1;
        tick();
        result_valid = 1; result_last = 0; result_data = 32'h9;
        tick();
        rst = 1;
        #1 chk("rst pop", 32'(result_pop), 32'd0);
        tick();
        rst = 0; fifo_populated = 0; result_valid = 0; wb_fb_instr = 0;
        #1;
        chk("rst done", 32'(wb_done), 32'd0);
        chk("rst rd", wb_rd, 32'd0);
        chk("rst id", 32'(wb_id_out), 32'd0);
        chk("rst iter", 32'(fb_iter_count), 32'd0);
        chk("rst err", 32'(protocol_err), 32'd0);
        tick();

        // Randomized traffic checked by the model each cycle.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            clear_fifos    = ($urandom_range(0, 24) == 0);
            fifo_populated = ($urandom_range(0, 3) != 0);
            wb_id          = IDW'($urandom);
            wb_fb_instr    = ($urandom_range(0, 2) == 0);
            result_valid   = ($urandom_range(0, 1) == 1);
            result_data    = $urandom;
            result_last    = ($urandom_range(0, 3) == 0);
            wb_ack         = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
